spi_tx_queue: RTL and testbench

SPI_TX_QUEUE -- requirements
Module: spi_tx_queue

---
 rtl/spi_tx_queue.sv | 126 ++++++++++++
 tb/tb_spi_tx_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_queue.sv
// SPI transmit queue: 9-bit {dc,data} FIFO feeding an SPI serializer
// through a three-state launch handshake.
`timescale 1ns/1ps
module spi_tx_queue #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               data_i,
   input  logic                     dc_i,
   input  logic                     write_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic                     idle_o,
   output logic [7:0]               spi_data_o,
   output logic                     spi_start_o,
   input  logic                     spi_busy_i,
   output logic                     dc_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      XFER   = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [8:0]     mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           overflow_q, overflow_d;
   logic [7:0]     data_q, data_d;
   logic           dc_q, dc_d;
   logic           wr_en;
   logic           pop;
   logic [8:0]     head;

   assign full_o      = (count_q == CW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;
   assign overflow_o  = overflow_q;
   assign spi_data_o  = data_q;
   assign dc_o        = dc_q;
   assign spi_start_o = (state_q == LAUNCH);
   assign idle_o      = (state_q == IDLE) & empty_o & ~spi_busy_i;

   // A full queue rejects writes even when a pop frees a slot this cycle.
   assign wr_en = write_i & ~full_o;
   assign head  = mem_q[rd_ptr_q];

   // Launch handshake: pop in IDLE, hold start until busy, wait for busy low.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty_o && !spi_busy_i) begin
               pop     = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            if (spi_busy_i) state_d = XFER;
         end
         XFER: begin
            if (!spi_busy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pointer, occupancy, overflow and output-latch next state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      data_d     = data_q;
      dc_d       = dc_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         data_d   = head[7:0];
         dc_d     = head[8];
      end
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (write_i && full_o) overflow_d = 1'b1;
   end

   // Storage array; reset only clears pointers, contents are don't-care.
   always_ff @(posedge clk_i) begin
      if (wr_en && !rst_i) mem_q[wr_ptr_q] <= {dc_i, data_i};
   end

   // Control state with synchronous reset taking priority over write/pop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         data_q     <= 8'h00;
         dc_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         data_q     <= data_d;
         dc_q       <= dc_d;
      end
   end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue with a behavioural serializer
// responder and a monitor logging every launched entry.
`timescale 1ns/1ps
module tb_spi_tx_queue;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [7:0] data_i;
   logic       dc_i;
   logic       write_i;
   logic       full_o, empty_o, overflow_o, idle_o;
   logic [4:0] count_o;
   logic [7:0] spi_data_o;
   logic       spi_start_o;
   logic       spi_busy_i;
   logic       dc_o;

   logic       force_busy = 1'b0;
   logic       model_busy = 1'b0;
   int         resp_n = 1;
   int         xfer_len = 3;
   int         wcnt = 0;
   int         bcnt = 0;

   logic       prev_start = 1'b0;
   logic       prev_rst = 1'b1;
   logic [8:0] prev_out = 9'h0;
   int         n_starts = 0;
   int         start_hi = 0;
   int         viol = 0;
   logic [8:0] log_q[$];

   int vectors = 0;
   int errs = 0;

   assign spi_busy_i = force_busy | model_busy;

   spi_tx_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .dc_i(dc_i),
      .write_i(write_i), .full_o(full_o), .empty_o(empty_o),
      .count_o(count_o), .overflow_o(overflow_o), .idle_o(idle_o),
      .spi_data_o(spi_data_o), .spi_start_o(spi_start_o),
      .spi_busy_i(spi_busy_i), .dc_o(dc_o)
   );

   always #5 clk = ~clk;

   // Serializer model and output monitor.
   always @(posedge clk) begin
      if (spi_start_o) start_hi <= start_hi + 1;
      if (spi_start_o && !prev_start) begin
         n_starts <= n_starts + 1;
         log_q.push_back({dc_o, spi_data_o});
      end
      if (!prev_rst && ({dc_o, spi_data_o} != prev_out) &&
          !(spi_start_o && !prev_start))
         viol <= viol + 1;
      prev_out   <= {dc_o, spi_data_o};
      prev_rst   <= rst_i;
      prev_start <= spi_start_o;
      if (model_busy) begin
         if (bcnt <= 1) model_busy <= 1'b0;
         bcnt <= bcnt - 1;
      end else if (spi_start_o && !force_busy) begin
         if (wcnt + 1 >= resp_n) begin
            model_busy <= 1'b1;
            bcnt       <= xfer_len;
            wcnt       <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int bound, input string tag);
      int n = 0;
      while (!idle_o && n < bound) begin
         tick();
         n++;
      end
      chk(tag, {31'b0, idle_o}, 32'd1);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      int s_starts, s_hi, s_viol, b;
      logic [8:0] e;
      rst_i = 1'b1; data_i = 8'h00; dc_i = 1'b0; write_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;

      chk("rst_empty", {31'b0, empty_o}, 1);
      chk("rst_full", {31'b0, full_o}, 0);
      chk("rst_count", {27'b0, count_o}, 0);
      chk("rst_ovf", {31'b0, overflow_o}, 0);
      chk("rst_start", {31'b0, spi_start_o}, 0);
      chk("rst_data", {24'b0, spi_data_o}, 0);
      chk("rst_dc", {31'b0, dc_o}, 0);
      chk("rst_idle", {31'b0, idle_o}, 1);

      // Single write latency
      resp_n = 1; xfer_len = 3;
      s_starts = n_starts;
      data_i = 8'hA5; dc_i = 1'b1; write_i = 1'b1;
      tick();
      write_i = 1'b0;
      chk("lat_count", {27'b0, count_o}, 1);
      chk("lat_nobypass", {31'b0, spi_start_o}, 0);
      tick();
      chk("lat_start", {31'b0, spi_start_o}, 1);
      chk("lat_data", {24'b0, spi_data_o}, 32'hA5);
      chk("lat_dc", {31'b0, dc_o}, 1);
      chk("lat_popped", {27'b0, count_o}, 0);
      chk("lat_notidle", {31'b0, idle_o}, 0);
      wait_idle(50, "lat_idle");
      chk("lat_pulses", n_starts - s_starts, 1);

      // Burst of DEPTH+1 with serializer held busy
      b = log_q.size();
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         data_i = 8'(8'h10 + i); dc_i = i[0]; write_i = 1'b1;
         tick();
      end
      chk("burst_full", {31'b0, full_o}, 1);
      chk("burst_count", {27'b0, count_o}, 16);
      chk("burst_noovf", {31'b0, overflow_o}, 0);
      data_i = 8'hEE; dc_i = 1'b1;
      tick();
      write_i = 1'b0;
      chk("burst_ovf", {31'b0, overflow_o}, 1);
      chk("burst_count17", {27'b0, count_o}, 16);
      force_busy = 1'b0;
      wait_idle(400, "burst_drain");
      chk("burst_logged", log_q.size() - b, 16);
      for (int i = 0; i < DEPTH; i++) begin
         e = {i[0], 8'(8'h10 + i)};
         chk("burst_order", {23'b0, log_q[b + i]}, {23'b0, e});
      end
      chk("burst_ovf_sticky", {31'b0, overflow_o}, 1);

      // Write while full on the same edge as a pop
      do_reset();
      chk("wf_ovf_clr", {31'b0, overflow_o}, 0);
      b = log_q.size();
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         data_i = 8'(8'h40 + i); dc_i = 1'b0; write_i = 1'b1;
         tick();
      end
      force_busy = 1'b0;
      data_i = 8'h77;
      tick();
      write_i = 1'b0;
      chk("wf_count", {27'b0, count_o}, 15);
      chk("wf_ovf", {31'b0, overflow_o}, 1);
      chk("wf_start", {31'b0, spi_start_o}, 1);
      chk("wf_head", {24'b0, spi_data_o}, 32'h40);
      wait_idle(400, "wf_drain");
      chk("wf_logged", log_q.size() - b, 16);

      // Slow serializer: busy arrives late, start held
      do_reset();
      resp_n = 3;
      s_starts = n_starts; s_hi = start_hi; b = log_q.size();
      data_i = 8'h3C; dc_i = 1'b0; write_i = 1'b1;
      tick();
      write_i = 1'b0;
      wait_idle(100, "slow_idle");
      chk("slow_hi", start_hi - s_hi, 4);
      chk("slow_pulses", n_starts - s_starts, 1);
      chk("slow_logged", log_q.size() - b, 1);
      chk("slow_byte", {23'b0, log_q[b]}, 32'h03C);

      // Reset during XFER with 3 entries queued
      resp_n = 1; xfer_len = 10;
      s_starts = n_starts;
      for (int i = 0; i < 4; i++) begin
         data_i = 8'(8'hB0 + i); dc_i = 1'b1; write_i = 1'b1;
         tick();
         if (i == 1) chk("rx_wr_pop_cnt", {27'b0, count_o}, 1);
      end
      chk("rx_count3", {27'b0, count_o}, 3);
      chk("rx_xfer_start", {31'b0, spi_start_o}, 0);
      chk("rx_busy", {31'b0, spi_busy_i}, 1);
      rst_i = 1'b1; data_i = 8'hCC;
      tick();
      rst_i = 1'b0; write_i = 1'b0;
      chk("rx_count0", {27'b0, count_o}, 0);
      chk("rx_empty", {31'b0, empty_o}, 1);
      chk("rx_data", {24'b0, spi_data_o}, 0);
      chk("rx_dc", {31'b0, dc_o}, 0);
      chk("rx_start", {31'b0, spi_start_o}, 0);
      chk("rx_idle_busy", {31'b0, idle_o}, 0);
      data_i = 8'h55; dc_i = 1'b0; write_i = 1'b1;
      tick();
      write_i = 1'b0;
      tick(); tick(); tick();
      chk("rx_hold_start", {31'b0, spi_start_o}, 0);
      chk("rx_hold_count", {27'b0, count_o}, 1);
      wait_idle(100, "rx_idle");
      chk("rx_pulses", n_starts - s_starts, 2);
      chk("rx_last", {23'b0, log_q[log_q.size() - 1]}, 32'h055);

      // Alternating command/data bytes
      xfer_len = 3;
      s_viol = viol; b = log_q.size();
      for (int i = 0; i < 4; i++) begin
         data_i = i[0] ? 8'h11 : 8'h2A; dc_i = i[0]; write_i = 1'b1;
         tick();
      end
      write_i = 1'b0;
      wait_idle(200, "alt_idle");
      chk("alt_logged", log_q.size() - b, 4);
      for (int i = 0; i < 4; i++) begin
         e = i[0] ? 9'h111 : 9'h02A;
         chk("alt_order", {23'b0, log_q[b + i]}, {23'b0, e});
      end
      chk("alt_viol", viol - s_viol, 0);
      chk("all_viol", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
